// File: rtl/multi_scoreboard.sv
// Multi-player BCD scoreboard: per-player goal edge detection with a shared lockout
// window, saturating BCD scores and an IDLE/PLAY/OVER game FSM.
module multi_scoreboard #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int WIN_SCORE   = 10,
    parameter int LOCKOUT     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dis_score,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          goal,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
    output logic                            game_over,
    output logic [2:0]                      winner,
    output logic                            busy
);

    localparam int SW = DIGITS * 4;
    localparam int LW = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);

    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] res;
        int            v;
        res = '0;
        v   = value;
        for (int d = 0; d < DIGITS; d++) begin
            res[d*4 +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return res;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam logic [SW-1:0] MAX_BCD = to_bcd((10 ** DIGITS) - 1);

    // Ripple BCD increment; an all-nines score saturates instead of wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] res;
        logic          carry;
        res   = v;
        carry = 1'b1;
        if (v != MAX_BCD) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (res[d*4 +: 4] == 4'd9) begin
                        res[d*4 +: 4] = 4'd0;
                    end else begin
                        res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t                        state_q, state_d;
    logic [NUM_PLAYERS*SW-1:0]     score_q, score_d;
    logic [NUM_PLAYERS-1:0]        goal_q;
    logic [LW-1:0]                 lock_q, lock_d;
    logic [2:0]                    winner_q, winner_d;
    logic                          over_q;
    logic                          busy_q;

    logic [NUM_PLAYERS-1:0]        edge_w;
    logic [SW-1:0]                 inc_score [NUM_PLAYERS];
    logic                          accept;
    logic                          found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign edge_w[gi]    = goal[gi] & ~goal_q[gi];
            assign inc_score[gi] = bcd_inc(score_q[gi*SW +: SW]);
        end
    endgenerate

    assign accept = (state_q == PLAY) && (lock_q == '0) && (|edge_w);

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        winner_d = winner_q;
        lock_d   = (lock_q != '0) ? lock_q - LW'(1) : lock_q;
        found    = 1'b0;
        if (!dis_score) begin
            state_d  = IDLE;
            score_d  = '0;
            winner_d = '0;
            lock_d   = '0;
        end else if (start) begin
            state_d  = PLAY;
            score_d  = '0;
            winner_d = '0;
            lock_d   = '0;
        end else if (accept) begin
            lock_d = LW'(LOCKOUT);
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (edge_w[i]) begin
                    score_d[i*SW +: SW] = inc_score[i];
                end
            end
            // Ascending scan so the lowest index wins a tie.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (!found && score_d[i*SW +: SW] == WIN_BCD) begin
                    found    = 1'b1;
                    winner_d = 3'(i);
                end
            end
            if (found) begin
                state_d = OVER;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            score_q  <= '0;
            goal_q   <= '0;
            lock_q   <= '0;
            winner_q <= '0;
            over_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            goal_q   <= goal;
            lock_q   <= lock_d;
            winner_q <= winner_d;
            over_q   <= (state_d == OVER);
            busy_q   <= (lock_d != '0);
        end
    end

    assign score     = score_q;
    assign game_over = over_q;
    assign winner    = winner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multi_scoreboard.sv
// Bench for multi_scoreboard: directed game scenarios plus random stimulus, all
// checked every cycle against an integer-score game model.
module tb_multi_scoreboard;

    localparam int NP   = 2;
    localparam int LOCK = 4;
    localparam int WIN  = 10;
    localparam int MAXS = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis_score, start;
    logic [1:0]  goal;
    logic [15:0] score;
    logic        game_over, busy;
    logic [2:0]  winner;

    logic        dis99, start99;
    logic [1:0]  goal99;
    logic [15:0] score99;
    logic        go99, busy99;
    logic [2:0]  win99;

    always #5 clk = ~clk;

    multi_scoreboard u_dut (
        .clk(clk), .rst(rst), .dis_score(dis_score), .start(start), .goal(goal),
        .score(score), .game_over(game_over), .winner(winner), .busy(busy)
    );

    multi_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(99), .LOCKOUT(4)) u_dut99 (
        .clk(clk), .rst(rst), .dis_score(dis99), .start(start99), .goal(goal99),
        .score(score99), .game_over(go99), .winner(win99), .busy(busy99)
    );

    int checks = 0;
    int errors = 0;

    // Game model: plain integer scores, state as 0=idle 1=play 2=over.
    int         m_sc [NP];
    int         m_state;
    int         m_lock;
    int         m_win;
    logic [1:0] m_gprev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_sc[i] = 0;
        m_state = 0;
        m_lock  = 0;
        m_win   = 0;
        m_gprev = '0;
    endtask

    task automatic model_edge();
        logic [1:0] e;
        bit         acc;
        e = goal & ~m_gprev;
        if (rst) begin
            model_reset();
        end else begin
            m_gprev = goal;
            if (!dis_score) begin
                m_state = 0;
                m_win   = 0;
                m_lock  = 0;
                for (int i = 0; i < NP; i++) m_sc[i] = 0;
            end else if (start) begin
                m_state = 1;
                m_win   = 0;
                m_lock  = 0;
                for (int i = 0; i < NP; i++) m_sc[i] = 0;
            end else begin
                acc = (m_state == 1) && (m_lock == 0) && (e != 0);
                if (m_lock > 0) m_lock--;
                if (acc) begin
                    m_lock = LOCK;
                    for (int i = 0; i < NP; i++)
                        if (e[i] && m_sc[i] < MAXS) m_sc[i]++;
                    for (int i = 0; i < NP; i++) begin
                        if (m_state == 1 && m_sc[i] == WIN) begin
                            m_state = 2;
                            m_win   = i;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        chk("score", score, bcd2(m_sc[1]) * 256 + bcd2(m_sc[0]));
        chk("game_over", game_over, (m_state == 2));
        chk("winner", winner, m_win);
        chk("busy", busy, (m_lock != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic pulse(input logic [1:0] g, input int gap);
        goal = g;
        step();
        goal = '0;
        repeat (gap) step();
    endtask

    initial begin
        rst = 1'b0; dis_score = 1'b0; start = 1'b0; goal = '0;
        dis99 = 1'b0; start99 = 1'b0; goal99 = '0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_score", score, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_score99", score99, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Goals while idle are discarded.
        dis_score = 1'b1;
        goal = 2'b01; step();
        goal = 2'b00; step();
        chk("idle_ignores_goal", score, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("start_score", score, 0);

        // Ten isolated goals for player 0.
        for (int n = 1; n <= 10; n++) begin
            goal = 2'b01; step();
            chk($sformatf("p0_goal_%0d", n), score[7:0], bcd2(n));
            if (n == 10) begin
                chk("p0_win_over", game_over, 1);
                chk("p0_win_winner", winner, 0);
            end
            goal = 2'b00;
            repeat (5) step();
        end
        chk("over_hold_score", score, 16'h0010);
        chk("over_hold_flag", game_over, 1);

        // Simultaneous goals and busy window.
        start = 1'b1; step(); start = 1'b0;
        chk("restart_score", score, 0);
        chk("restart_over", game_over, 0);
        goal = 2'b11; step();
        chk("both_01", score, 16'h0101);
        chk("busy_1", busy, 1);
        goal = 2'b00;
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("busy_%0d", k), busy, 1);
        end
        step();
        chk("busy_end", busy, 0);

        // Goal inside lockout is dropped, after lockout it counts.
        repeat (2) step();
        goal = 2'b01; step();
        goal = 2'b00; step();
        goal = 2'b10; step();
        chk("lockout_ignored", score, 16'h0102);
        goal = 2'b00; step(); step();
        goal = 2'b10; step();
        chk("after_lockout", score, 16'h0202);
        goal = 2'b00; repeat (5) step();

        // Tie at WIN_SCORE resolves to player 0.
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n <= 9; n++) pulse(2'b11, 5);
        chk("both_09", score, 16'h0909);
        chk("both_09_over", game_over, 0);
        goal = 2'b11; step();
        chk("tie_score", score, 16'h1010);
        chk("tie_over", game_over, 1);
        chk("tie_winner", winner, 0);
        goal = 2'b00; step();

        // Player 1 wins alone.
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n <= 10; n++) pulse(2'b10, 5);
        chk("p1_win_winner", winner, 1);
        chk("p1_win_score", score, 16'h1000);

        // Goal held high across start produces no increment.
        goal = 2'b01; step();
        start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        chk("held_goal", score, 0);
        goal = 2'b00; step();
        goal = 2'b01; step();
        chk("regoal", score, 16'h0001);
        goal = 2'b00; repeat (5) step();

        // Asynchronous reset mid-game.
        pulse(2'b01, 5);
        chk("pre_rst_score", score, 16'h0002);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_score", score, 0);
        chk("async_rst_over", game_over, 0);
        chk("async_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        // dis_score low beats start and goal.
        start = 1'b1; step(); start = 1'b0;
        pulse(2'b01, 5);
        dis_score = 1'b0; start = 1'b1; goal = 2'b10; step();
        chk("dis_priority_score", score, 0);
        dis_score = 1'b1; start = 1'b0; goal = 2'b00; step();
        goal = 2'b01; step();
        chk("dis_idle_score", score, 0);
        goal = 2'b00; step();

        // Random traffic.
        repeat (1500) begin
            dis_score = ($urandom_range(0, 49) != 0);
            start     = ($urandom_range(0, 39) == 0);
            goal      = 2'($urandom_range(0, 3));
            step();
        end
        dis_score = 1'b1; start = 1'b0; goal = '0;

        // WIN_SCORE=99 instance: reach 98, win at 99, then disable.
        dis99 = 1'b1; start99 = 1'b1; step(); start99 = 1'b0;
        for (int n = 1; n <= 98; n++) begin
            goal99 = 2'b01; step();
            goal99 = 2'b00; repeat (5) step();
        end
        chk("w99_score98", score99, 16'h0098);
        chk("w99_not_over", go99, 0);
        goal99 = 2'b01; step();
        chk("w99_score99", score99, 16'h0099);
        chk("w99_over", go99, 1);
        chk("w99_winner", win99, 0);
        goal99 = 2'b00; dis99 = 1'b0; step();
        chk("w99_dis_score", score99, 0);
        chk("w99_dis_over", go99, 0);
        chk("w99_dis_busy", busy99, 0);
        dis99 = 1'b1; step();
        chk("w99_idle_over", go99, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
